// File: rtl/fifo_pkg.sv
// Constants and state types shared by the async FIFO write-side producer and read-side packer.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_BYTES  = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2
    } fsm_rd_e;

endpackage

// File: rtl/fifo_out_reg.sv
// Output word register for the read-side packer: holds valid/data/keep stable until accepted.
module fifo_out_reg #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o
);

    logic              valid_q;
    logic [WORD_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;

    // The owner only asserts load_i when the register is free, so load wins over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops bytes, packs them little-endian into words, and flushes partial words on request.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned BYTES  = FIFO_BYTES,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic                    rempty,
    input  logic [DATA_W-1:0]       rdata,
    output logic                    rinc,
    input  logic                    flush,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W*BYTES-1:0] m_data,
    output logic [BYTES-1:0]        m_keep,
    output logic [CNT_W-1:0]        word_cnt,
    output logic                    busy
);

    localparam int unsigned WORD_W = DATA_W * BYTES;
    localparam int unsigned ACNT_W = $clog2(BYTES + 1);
    localparam int unsigned SUM_W  = ACNT_W + 1;

    fsm_rd_e             state_q, state_d;
    logic [ACNT_W-1:0]   asm_cnt_q, asm_cnt_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic                inflight_q;
    logic [CNT_W-1:0]    word_cnt_q;

    logic                full_c;
    logic                out_free_c;
    logic                xfer_c;
    logic [SUM_W-1:0]    occ_c;
    logic [ACNT_W-1:0]   lane_c;
    logic                load_c;
    logic [WORD_W-1:0]   load_data_c;
    logic [BYTES-1:0]    load_keep_c;

    function automatic logic [BYTES-1:0] keep_mask(input logic [ACNT_W-1:0] n);
        logic [BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (ACNT_W'(i) < n);
        end
        return m;
    endfunction

    assign full_c     = (asm_cnt_q == ACNT_W'(BYTES));
    assign out_free_c = !m_valid || m_ready;
    assign xfer_c     = full_c && out_free_c;
    // Bytes owned after this cycle: assembled plus in flight, minus a word leaving now.
    assign occ_c      = SUM_W'(asm_cnt_q) + SUM_W'(inflight_q) - (xfer_c ? SUM_W'(BYTES) : SUM_W'(0));
    assign lane_c     = xfer_c ? ACNT_W'(0) : asm_cnt_q;

    // Reset gates the pop so nothing leaves the FIFO while the packer cannot capture it.
    assign rinc = rrst_n && (state_q == RUN) && !rempty && (occ_c < SUM_W'(BYTES));

    always_comb begin
        state_d     = state_q;
        asm_cnt_d   = asm_cnt_q;
        asm_d       = asm_q;
        load_c      = 1'b0;
        load_data_c = asm_q;
        load_keep_c = '1;

        if (xfer_c) begin
            load_c    = 1'b1;
            asm_cnt_d = '0;
        end

        if (inflight_q) begin
            asm_d[32'(lane_c) * DATA_W +: DATA_W] = rdata;
            asm_cnt_d = lane_c + ACNT_W'(1);
        end

        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (full_c) begin
                    if (xfer_c) begin
                        state_d = RUN;
                    end
                end else if (asm_cnt_q == '0) begin
                    state_d = RUN;
                end else if (out_free_c) begin
                    // Partial word: keep the low lanes, zero the stale ones.
                    load_c      = 1'b1;
                    load_keep_c = keep_mask(asm_cnt_q);
                    for (int i = 0; i < BYTES; i++) begin
                        if (!load_keep_c[i]) begin
                            load_data_c[i*DATA_W +: DATA_W] = '0;
                        end
                    end
                    asm_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= RUN;
            asm_cnt_q  <= '0;
            asm_q      <= '0;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            asm_cnt_q  <= asm_cnt_d;
            asm_q      <= asm_d;
            inflight_q <= rinc;
            if (m_valid && m_ready) begin
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
        end
    end

    fifo_out_reg #(
        .WORD_W (WORD_W),
        .KEEP_W (BYTES)
    ) u_out_reg (
        .clk     (rclk),
        .rst_n   (rrst_n),
        .load_i  (load_c),
        .data_i  (load_data_c),
        .keep_i  (load_keep_c),
        .ready_i (m_ready),
        .valid_o (m_valid),
        .data_o  (m_data),
        .keep_o  (m_keep)
    );

    assign word_cnt = word_cnt_q;
    assign busy     = (state_q != RUN);

endmodule
